// File: rtl/cr_prefix_attach_fetch_pkg.sv
// -----------------------------------------------------------------------------
// cr_prefix_attach_fetch_pkg
// Shared types and constants for the prefix-attach fetch engine:
//   - default geometry of the PHD/PFD register-file memories
//   - beat tag carried alongside each memory read through the return pipe
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package cr_prefix_attach_fetch_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int PHD_ENTRIES_DEF = 128;
  localparam int PFD_WORDS_DEF   = 8;
  localparam int PFD_ENTRIES_DEF = PHD_ENTRIES_DEF * PFD_WORDS_DEF;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int FIFO_DEPTH_MIN  = 3;

  // Framing attached to a read when it is issued; becomes sop/eop in the FIFO.
  typedef struct packed {
    logic is_hdr;
    logic is_last;
  } beat_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cr_prefix_attach_fetch_fifo.sv
// -----------------------------------------------------------------------------
// cr_prefix_attach_fetch_fifo
// First-word-fall-through FIFO with occupancy output.
//   clk, rst      clock, asynchronous active-high reset (pointers/count only)
//   i_wr_en       push i_wr_data (ignored when full)
//   i_rd_en       pop the head (ignored when empty)
//   o_rd_data     current head, valid whenever !o_empty
//   o_empty       no entries
//   o_count       number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module cr_prefix_attach_fetch_fifo #(
  parameter  int WIDTH = 66,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_wr_en && !w_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/cr_prefix_attach_fetch.sv
// -----------------------------------------------------------------------------
// cr_prefix_attach_fetch
// Fetches one prefix (PHD header entry + PFD_WORDS data entries) from the
// prefix-attach register file and emits it as one sop/eop framed beat stream.
//   req_valid/req_ready/req_prefix   fetch request handshake
//   phd_mem_addr/cs/yield/dout       PHD read port (dout 2 cycles after access)
//   pfd_mem_addr/cs/yield/dout       PFD read port (dout 2 cycles after access)
//   out_valid/ready/data/sop/eop     framed output stream (FIFO head)
//   busy                             FSM active, reads in flight or FIFO busy
// Reads are only issued while the FIFO can absorb every outstanding read, so
// the memory pipe never needs to stall.
// -----------------------------------------------------------------------------
module cr_prefix_attach_fetch
  import cr_prefix_attach_fetch_pkg::*;
#(
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int PHD_ENTRIES = PHD_ENTRIES_DEF,
  parameter  int PFD_WORDS   = PFD_WORDS_DEF,
  parameter  int PFD_ENTRIES = PHD_ENTRIES * PFD_WORDS,
  parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  localparam int PHD_AW      = $clog2(PHD_ENTRIES),
  localparam int PFD_AW      = $clog2(PFD_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PHD_AW-1:0] req_prefix,
  output logic [PHD_AW-1:0] phd_mem_addr,
  output logic              phd_mem_cs,
  input  logic              phd_mem_yield,
  input  logic [DATA_W-1:0] phd_mem_dout,
  output logic [PFD_AW-1:0] pfd_mem_addr,
  output logic              pfd_mem_cs,
  input  logic              pfd_mem_yield,
  input  logic [DATA_W-1:0] pfd_mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy
);

  localparam int IDX_W  = (PFD_WORDS > 1) ? $clog2(PFD_WORDS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int USED_W = CNT_W + 1;
  localparam int FIFO_W = DATA_W + 2;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [PHD_AW-1:0] r_pfx;
  logic              w_pfx_load;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_last_idx;

  logic              w_credit;
  logic [USED_W-1:0] w_used;

  logic              w_vld_p0;
  beat_tag_t         w_tag_p0;
  logic              r_vld_p1;
  beat_tag_t         r_tag_p1;
  logic              r_vld_p2;
  beat_tag_t         r_tag_p2;

  logic [FIFO_W-1:0] w_fifo_wdata;
  logic [FIFO_W-1:0] w_fifo_rdata;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_pop;

  // Every accepted read ends up in the FIFO, so the FIFO plus the reads still
  // in the memory pipe must leave room before another read may be issued.
  // Deliberately independent of yield.
  assign w_used   = USED_W'(w_fifo_count) + USED_W'(r_vld_p1) + USED_W'(r_vld_p2);
  assign w_credit = (w_used < USED_W'(FIFO_DEPTH));

  assign w_last_idx   = (r_idx == IDX_W'(PFD_WORDS - 1));
  assign phd_mem_addr = r_pfx;
  assign pfd_mem_addr = PFD_AW'(r_pfx) * PFD_AW'(PFD_WORDS) + PFD_AW'(r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pfx_load  = 1'b0;
    req_ready   = 1'b0;
    phd_mem_cs  = 1'b0;
    pfd_mem_cs  = 1'b0;
    w_vld_p0    = 1'b0;
    w_tag_p0    = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_pfx_load  = 1'b1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        phd_mem_cs = w_credit;
        if (w_credit && !phd_mem_yield) begin
          w_vld_p0        = 1'b1;
          w_tag_p0.is_hdr = 1'b1;
          w_idx_nxt       = '0;
          w_state_nxt     = ST_DATA;
        end
      end
      ST_DATA: begin
        pfd_mem_cs = w_credit;
        if (w_credit && !pfd_mem_yield) begin
          w_vld_p0         = 1'b1;
          w_tag_p0.is_last = w_last_idx;
          if (w_last_idx) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pfx   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pfx_load) r_pfx <= req_prefix;
    end
  end

  // ---- stage p0 -> p1: read accepted by the memory this cycle ----
  // ---- stage p1 -> p2: memory dout for the p2 tag is on the bus ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_tag_p1 <= w_tag_p0;
    r_tag_p2 <= r_tag_p1;
  end

  // ---- stage p2 -> FIFO: capture returning data with its framing ----
  assign w_fifo_wdata = {r_tag_p2.is_hdr, r_tag_p2.is_last,
                         r_tag_p2.is_hdr ? phd_mem_dout : pfd_mem_dout};

  cr_prefix_attach_fetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_vld_p2),
    .i_wr_data (w_fifo_wdata),
    .i_rd_en   (w_fifo_pop),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Payload is forced to zero while empty so the unreset storage never leaks.
  assign out_valid  = !w_fifo_empty;
  assign w_fifo_pop = out_valid && out_ready;
  assign out_data   = out_valid ? w_fifo_rdata[DATA_W-1:0] : '0;
  assign out_eop    = out_valid && w_fifo_rdata[DATA_W];
  assign out_sop    = out_valid && w_fifo_rdata[DATA_W+1];

  assign busy = (r_state != ST_IDLE) || r_vld_p1 || r_vld_p2 || !w_fifo_empty;

endmodule

// File: tb/tb_cr_prefix_attach_fetch.sv
module tb_cr_prefix_attach_fetch;

  localparam int DATA_W      = 64;
  localparam int PHD_ENTRIES = 128;
  localparam int PFD_WORDS   = 8;
  localparam int PFD_ENTRIES = 1024;
  localparam int FIFO_DEPTH  = 4;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_prefix;
  logic [6:0]        phd_mem_addr;
  logic              phd_mem_cs;
  logic              phd_mem_yield;
  logic [DATA_W-1:0] phd_mem_dout;
  logic [9:0]        pfd_mem_addr;
  logic              pfd_mem_cs;
  logic              pfd_mem_yield;
  logic [DATA_W-1:0] pfd_mem_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              busy;

  cr_prefix_attach_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_prefix    (req_prefix),
    .phd_mem_addr  (phd_mem_addr),
    .phd_mem_cs    (phd_mem_cs),
    .phd_mem_yield (phd_mem_yield),
    .phd_mem_dout  (phd_mem_dout),
    .pfd_mem_addr  (pfd_mem_addr),
    .pfd_mem_cs    (pfd_mem_cs),
    .pfd_mem_yield (pfd_mem_yield),
    .pfd_mem_dout  (pfd_mem_dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register-file model: contents random, data returns 2 cycles after access.
  logic [DATA_W-1:0] phd_arr [PHD_ENTRIES];
  logic [DATA_W-1:0] pfd_arr [PFD_ENTRIES];
  logic       phd_v1 = 1'b0, phd_v2 = 1'b0, pfd_v1 = 1'b0, pfd_v2 = 1'b0;
  logic [6:0] phd_a1 = '0, phd_a2 = '0;
  logic [9:0] pfd_a1 = '0, pfd_a2 = '0;

  always @(posedge clk) begin
    phd_v1 <= phd_mem_cs && !phd_mem_yield;
    phd_a1 <= phd_mem_addr;
    phd_v2 <= phd_v1;
    phd_a2 <= phd_a1;
    pfd_v1 <= pfd_mem_cs && !pfd_mem_yield;
    pfd_a1 <= pfd_mem_addr;
    pfd_v2 <= pfd_v1;
    pfd_a2 <= pfd_a1;
  end

  assign phd_mem_dout = phd_v2 ? phd_arr[phd_a2] : JUNK;
  assign pfd_mem_dout = pfd_v2 ? pfd_arr[pfd_a2] : ~JUNK;

  // Reference model: expected read order and expected beat stream.
  typedef struct {
    logic        is_pfd;
    logic [31:0] addr;
  } rd_t;
  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  rd_t   exp_rd[$];
  beat_t exp_beat[$];
  int unsigned acc_cnt = 0;
  int unsigned pop_cnt = 0;

  always @(negedge clk) begin
    int    p;
    rd_t   r;
    beat_t b;
    if (!rst) begin
      chk("busy", 64'(busy), 64'(exp_beat.size() != 0));
      chk("cs_excl", 64'(phd_mem_cs && pfd_mem_cs), 64'(0));
      if (phd_mem_cs || pfd_mem_cs)
        chk("credit", 64'((acc_cnt - pop_cnt) < FIFO_DEPTH), 64'(1));
      if ((phd_mem_cs && !phd_mem_yield) || (pfd_mem_cs && !pfd_mem_yield)) begin
        chk("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
        if (exp_rd.size() != 0) begin
          r = exp_rd.pop_front();
          if (phd_mem_cs) begin
            chk("rd_port_phd", 64'(r.is_pfd), 64'(0));
            chk("phd_addr", 64'(phd_mem_addr), 64'(r.addr));
          end else begin
            chk("rd_port_pfd", 64'(r.is_pfd), 64'(1));
            chk("pfd_addr", 64'(pfd_mem_addr), 64'(r.addr));
          end
        end
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 64'(exp_beat.size() != 0), 64'(1));
        if (exp_beat.size() != 0) begin
          b = exp_beat.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_sop", 64'(out_sop), 64'(b.sop));
          chk("beat_eop", 64'(out_eop), 64'(b.eop));
        end
        pop_cnt++;
      end
      if (req_valid && req_ready) begin
        p = int'(req_prefix);
        r.is_pfd = 1'b0; r.addr = 32'(p);
        exp_rd.push_back(r);
        b.d = phd_arr[p]; b.sop = 1'b1; b.eop = 1'b0;
        exp_beat.push_back(b);
        for (int i = 0; i < PFD_WORDS; i++) begin
          r.is_pfd = 1'b1; r.addr = 32'(p * PFD_WORDS + i);
          exp_rd.push_back(r);
          b.d = pfd_arr[p * PFD_WORDS + i]; b.sop = 1'b0; b.eop = (i == PFD_WORDS - 1);
          exp_beat.push_back(b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    req_valid     = 1'b0;
    phd_mem_yield = 1'b0;
    pfd_mem_yield = 1'b0;
    out_ready     = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    quiet_inputs();
    n = 0;
    @(negedge clk);
    while ((exp_beat.size() != 0 || busy) && n < 300) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 300), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < PHD_ENTRIES; i++) phd_arr[i] = {$urandom, $urandom};
    for (int i = 0; i < PFD_ENTRIES; i++) pfd_arr[i] = {$urandom, $urandom};
    rst = 1'b1;
    req_prefix = '0;
    quiet_inputs();
    out_ready = 1'b0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cs", 64'({phd_mem_cs, pfd_mem_cs}), 64'(0));
    chk("rst_addr", 64'({phd_mem_addr, pfd_mem_addr}), 64'(0));
    repeat (3) tick();
    rst = 1'b0;
    quiet_inputs();
    tick();

    // Prefix 5, ideal conditions: exact issue and output timing.
    req_valid = 1'b1; req_prefix = 7'd5;
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'(1));
    for (int c = 1; c <= 13; c++) begin
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("t1_phd_cs", 64'(phd_mem_cs), 64'(c == 1));
      if (c == 1) chk("t1_phd_addr", 64'(phd_mem_addr), 64'(5));
      chk("t1_pfd_cs", 64'(pfd_mem_cs), 64'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk("t1_pfd_addr", 64'(pfd_mem_addr), 64'(40 + c - 2));
      chk("t1_out_valid", 64'(out_valid), 64'(c >= 4 && c <= 12));
      if (c == 4) chk("t1_sop", 64'(out_sop), 64'(1));
      if (c == 12) chk("t1_eop", 64'(out_eop), 64'(1));
    end
    drain("t1_drain");

    // Prefix 0, PFD yield held 3 cycles on idx 2.
    tick();
    req_valid = 1'b1; req_prefix = 7'd0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req_valid = 1'b0;
      pfd_mem_yield = (c >= 4 && c <= 6);
      @(negedge clk);
      if (c >= 4 && c <= 7) begin
        chk("t2_hold_cs", 64'(pfd_mem_cs), 64'(1));
        chk("t2_hold_addr", 64'(pfd_mem_addr), 64'(2));
      end
      if (c == 8) chk("t2_next_addr", 64'(pfd_mem_addr), 64'(3));
    end
    drain("t2_drain");

    // Output stalled after the first beat: issue must stop at the credit limit.
    tick();
    req_valid = 1'b1; req_prefix = 7'($urandom_range(127));
    for (int c = 1; c <= 20; c++) begin
      tick();
      req_valid = 1'b0;
      out_ready = (c <= 4);
    end
    @(negedge clk);
    chk("t3_stall_phd_cs", 64'(phd_mem_cs), 64'(0));
    chk("t3_stall_pfd_cs", 64'(pfd_mem_cs), 64'(0));
    chk("t3_stall_valid", 64'(out_valid), 64'(1));
    chk("t3_stall_outstanding", 64'(acc_cnt - pop_cnt), 64'(FIFO_DEPTH));
    drain("t3_drain");

    // Back-to-back requests 0 then 127.
    tick();
    req_valid = 1'b1; req_prefix = 7'd0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req_prefix = 7'd127;
      @(negedge clk);
      chk("t4_req_ready", 64'(req_ready), 64'(c == 10));
      if (c == 9) chk("t4_last_addr", 64'(pfd_mem_addr), 64'(7));
    end
    drain("t4_drain");

    // Reset in the middle of DATA with two beats queued.
    tick();
    req_valid = 1'b1; req_prefix = 7'($urandom_range(127));
    out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      req_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'(0));
    chk("t5_req_ready", 64'(req_ready), 64'(1));
    chk("t5_busy", 64'(busy), 64'(0));
    exp_rd.delete();
    exp_beat.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_stale", 64'(out_valid), 64'(0));
      tick();
    end

    // Prefix 127 with PHD yield for 2 cycles.
    req_valid = 1'b1; req_prefix = 7'd127;
    for (int c = 1; c <= 4; c++) begin
      tick();
      req_valid = 1'b0;
      phd_mem_yield = (c <= 2);
      @(negedge clk);
      if (c <= 3) chk("t6_phd_addr", 64'(phd_mem_addr), 64'(127));
      if (c == 4) chk("t6_first_pfd", 64'(pfd_mem_addr), 64'(1016));
    end
    drain("t6_drain");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_valid     = 1'($urandom_range(1));
      req_prefix    = 7'($urandom_range(127));
      phd_mem_yield = ($urandom_range(99) < 25);
      pfd_mem_yield = ($urandom_range(99) < 25);
      out_ready     = ($urandom_range(99) < 70);
    end
    drain("rand_drain");
    chk("rand_rd_left", 64'(exp_rd.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
